// File: rtl/ifchain_match_regfile.sv
// ---------------------------------------------------------------------------
// ifchain_match_regfile
//
// Purpose:
//   Compares a key {b,a} against N_RULES runtime-programmable masked-pattern
//   rules. The lowest-index enabled matching rule wins and writes its value
//   into one entry of a DEPTH x ENTRY_W register array, one cycle after the
//   input is presented. Keeps a sticky status flag, a saturating hit counter
//   and a registered read port into the array.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   in_valid, a, b     key input; key = {b,a}
//   cfg_we .. cfg_value rule programming port (one rule per cycle)
//   status_clr         clears the sticky status flag (a same-cycle hit wins)
//   rd_addr, rd_data   registered array read (0 for out-of-range address)
//   hit_valid, hit_rule one-cycle hit pulse and winning rule index
//   miss               one-cycle pulse: valid key matched no rule
//   status, hit_count  sticky hit flag, saturating hit counter
// ---------------------------------------------------------------------------
module ifchain_match_regfile #(
   parameter int DATA_W  = 4,
   parameter int N_RULES = 4,
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 32,
   parameter int CNT_W   = 8,
   parameter int KEY_W   = 2 * DATA_W,
   parameter int RIDX_W  = (N_RULES > 1) ? $clog2(N_RULES) : 1,
   parameter int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   input  logic               cfg_we,
   input  logic [RIDX_W-1:0]  cfg_idx,
   input  logic               cfg_en,
   input  logic [KEY_W-1:0]   cfg_mask,
   input  logic [KEY_W-1:0]   cfg_pat,
   input  logic [ADDR_W-1:0]  cfg_entry,
   input  logic [ENTRY_W-1:0] cfg_value,
   input  logic               status_clr,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               hit_valid,
   output logic [RIDX_W-1:0]  hit_rule,
   output logic               miss,
   output logic               status,
   output logic [CNT_W-1:0]   hit_count
);

   // Rule storage
   logic               en_q    [N_RULES];
   logic [KEY_W-1:0]   mask_q  [N_RULES];
   logic [KEY_W-1:0]   pat_q   [N_RULES];
   logic [ADDR_W-1:0]  entry_q [N_RULES];
   logic [ENTRY_W-1:0] value_q [N_RULES];

   // Register array
   logic [ENTRY_W-1:0] arr_q [DEPTH];

   // Output registers
   logic [ENTRY_W-1:0] rd_data_q;
   logic               hit_valid_q;
   logic [RIDX_W-1:0]  hit_rule_q;
   logic               miss_q;
   logic               status_q;
   logic [CNT_W-1:0]   hit_count_q;

   logic [KEY_W-1:0]   key;
   logic               match_any;
   logic [RIDX_W-1:0]  win_idx;
   logic               hit;
   logic               wr_ok;
   logic               rd_ok;
   logic               cfg_ok;

   assign key = {b, a};

   // Scan from the highest index down so the lowest matching index is the
   // last one assigned and therefore wins, mirroring an if/else-if chain.
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned; otherwise a latch is inferred.
   always_comb begin
      match_any = 1'b0;
      win_idx   = '0;
      for (int i = N_RULES - 1; i >= 0; i--) begin
         if (en_q[i] && (((key ^ pat_q[i]) & mask_q[i]) == '0)) begin
            match_any = 1'b1;
            win_idx   = RIDX_W'(i);
         end
      end
   end

   assign hit    = in_valid && match_any;
   // Widened by one bit so the range checks stay meaningful for
   // non-power-of-two sizes.
   assign wr_ok  = {1'b0, entry_q[win_idx]} < (ADDR_W + 1)'(DEPTH);
   assign rd_ok  = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);
   assign cfg_ok = {1'b0, cfg_idx} < (RIDX_W + 1)'(N_RULES);

   // Rules and array share one process: a rule write and a hit in the same
   // cycle both sample the pre-edge rule contents.
   // NOTE: rule and array storage must come out of reset as zero, so the
   // arrays sit inside the reset branch instead of being left uninitialised.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_RULES; i++) begin
            en_q[i]    <= 1'b0;
            mask_q[i]  <= '0;
            pat_q[i]   <= '0;
            entry_q[i] <= '0;
            value_q[i] <= '0;
         end
         for (int j = 0; j < DEPTH; j++) begin
            arr_q[j] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments make every register update at the
         // edge from pre-edge values, which is what gives the old-rule and
         // old-read-data behaviour for same-cycle collisions.
         if (cfg_we && cfg_ok) begin
            en_q[cfg_idx]    <= cfg_en;
            mask_q[cfg_idx]  <= cfg_mask;
            pat_q[cfg_idx]   <= cfg_pat;
            entry_q[cfg_idx] <= cfg_entry;
            value_q[cfg_idx] <= cfg_value;
         end
         if (hit && wr_ok) begin
            arr_q[entry_q[win_idx]] <= value_q[win_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data_q   <= '0;
         hit_valid_q <= 1'b0;
         hit_rule_q  <= '0;
         miss_q      <= 1'b0;
         status_q    <= 1'b0;
         hit_count_q <= '0;
      end else begin
         rd_data_q   <= rd_ok ? arr_q[rd_addr] : '0;
         hit_valid_q <= hit;
         hit_rule_q  <= hit ? win_idx : '0;
         miss_q      <= in_valid && !match_any;
         // Set has priority over clear.
         if (hit) begin
            status_q <= 1'b1;
         end else if (status_clr) begin
            status_q <= 1'b0;
         end
         if (hit && (hit_count_q != {CNT_W{1'b1}})) begin
            hit_count_q <= hit_count_q + 1'b1;
         end
      end
   end

   assign rd_data   = rd_data_q;
   assign hit_valid = hit_valid_q;
   assign hit_rule  = hit_rule_q;
   assign miss      = miss_q;
   assign status    = status_q;
   assign hit_count = hit_count_q;

endmodule

// File: tb/tb_ifchain_match_regfile.sv
// ---------------------------------------------------------------------------
// tb_ifchain_match_regfile
//
// Purpose:
//   Directed self-checking bench. Each issued key pushes its expected
//   {hit_valid, hit_rule, miss, status, hit_count} into a queue; a monitor
//   pops and compares whenever the DUT pulses hit_valid or miss. Array reads
//   and reset values are compared directly with check().
// ---------------------------------------------------------------------------
module tb_ifchain_match_regfile;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  a = '0;
   logic [3:0]  b = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic        cfg_en = 1'b0;
   logic [7:0]  cfg_mask = '0;
   logic [7:0]  cfg_pat = '0;
   logic [1:0]  cfg_entry = '0;
   logic [31:0] cfg_value = '0;
   logic        status_clr = 1'b0;
   logic [1:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        hit_valid;
   logic [1:0]  hit_rule;
   logic        miss;
   logic        status;
   logic [7:0]  hit_count;

   typedef struct packed {
      logic       hit_valid;
      logic [1:0] hit_rule;
      logic       miss;
      logic       status;
      logic [7:0] hit_count;
   } resp_t;

   resp_t exp_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   ifchain_match_regfile dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .a          (a),
      .b          (b),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_en     (cfg_en),
      .cfg_mask   (cfg_mask),
      .cfg_pat    (cfg_pat),
      .cfg_entry  (cfg_entry),
      .cfg_value  (cfg_value),
      .status_clr (status_clr),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .hit_valid  (hit_valid),
      .hit_rule   (hit_rule),
      .miss       (miss),
      .status     (status),
      .hit_count  (hit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge and drop one-cycle strobes.
   task automatic tick();
      @(negedge clk);
      cfg_we     = 1'b0;
      in_valid   = 1'b0;
      status_clr = 1'b0;
   endtask

   task automatic set_rule(input logic [1:0] idx, input logic en, input logic [7:0] mask,
                           input logic [7:0] pat, input logic [1:0] entry, input logic [31:0] value);
      cfg_we    = 1'b1;
      cfg_idx   = idx;
      cfg_en    = en;
      cfg_mask  = mask;
      cfg_pat   = pat;
      cfg_entry = entry;
      cfg_value = value;
   endtask

   // Drive a key for the coming edge and queue its expected response.
   task automatic issue(input logic [7:0] key, input logic e_hit, input logic [1:0] e_rule,
                        input logic e_miss, input logic e_status, input logic [7:0] e_cnt);
      resp_t r;
      in_valid = 1'b1;
      {b, a}   = key;
      r.hit_valid = e_hit;
      r.hit_rule  = e_rule;
      r.miss      = e_miss;
      r.status    = e_status;
      r.hit_count = e_cnt;
      exp_q.push_back(r);
   endtask

   task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
      rd_addr = addr;
      tick();
      check(name, rd_data, exp);
   endtask

   // Monitor: compares each presented response with the oldest expectation.
   initial begin
      resp_t act;
      resp_t exp;
      forever begin
         @(posedge clk);
         #1;
         if (hit_valid || miss) begin
            act = {hit_valid, hit_rule, miss, status, hit_count};
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_resp: got %h, expected none", act);
            end else begin
               exp = exp_q.pop_front();
               check("resp", 32'(act), 32'(exp));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;

      // Reset state
      #2;
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_flags", {29'h0, hit_valid, miss, status}, 32'h0);
      check("rst_count", {24'h0, hit_count}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // 1: basic hit on rule 0
      set_rule(2'd0, 1'b1, 8'h2C, 8'h04, 2'd0, 32'h0000FFFF);
      tick();
      issue(8'h04, 1'b1, 2'd0, 1'b0, 1'b1, 8'd1);
      tick();
      read_check("t1_entry0", 2'd0, 32'h0000FFFF);

      // 2: masked bit differs -> miss, array unchanged
      issue(8'h0C, 1'b0, 2'd0, 1'b1, 1'b1, 8'd1);
      tick();
      read_check("t2_entry0", 2'd0, 32'h0000FFFF);

      // 3: priority between rule 1 and catch-all rule 3
      set_rule(2'd1, 1'b1, 8'hFF, 8'h5A, 2'd1, 32'h11111111);
      tick();
      set_rule(2'd3, 1'b1, 8'h00, 8'h00, 2'd2, 32'hA5A5A5A5);
      tick();
      issue(8'h5A, 1'b1, 2'd1, 1'b0, 1'b1, 8'd2);
      tick();
      read_check("t3_entry1", 2'd1, 32'h11111111);
      read_check("t3_entry2_old", 2'd2, 32'h0);
      set_rule(2'd1, 1'b0, 8'hFF, 8'h5A, 2'd1, 32'h11111111);
      tick();
      issue(8'h5A, 1'b1, 2'd3, 1'b0, 1'b1, 8'd3);
      tick();
      read_check("t3_entry2_new", 2'd2, 32'hA5A5A5A5);

      // 4: same-cycle rule rewrite uses the old rule
      set_rule(2'd3, 1'b0, 8'h00, 8'h00, 2'd2, 32'hA5A5A5A5);
      tick();
      set_rule(2'd0, 1'b1, 8'h2C, 8'h00, 2'd0, 32'h0000FFFF);
      issue(8'h04, 1'b1, 2'd0, 1'b0, 1'b1, 8'd4);
      tick();
      issue(8'h04, 1'b0, 2'd0, 1'b1, 1'b1, 8'd4);
      tick();

      // Read of an entry written in the same cycle returns the old value
      set_rule(2'd2, 1'b1, 8'hFF, 8'h77, 2'd3, 32'hDEADBEEF);
      tick();
      issue(8'h77, 1'b1, 2'd2, 1'b0, 1'b1, 8'd5);
      read_check("rd_collide_old", 2'd3, 32'h0);
      read_check("rd_collide_new", 2'd3, 32'hDEADBEEF);

      // 5: status set wins over clear; clear alone; counter saturation
      issue(8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 8'd6);
      status_clr = 1'b1;
      tick();
      check("status_set_wins", {31'h0, status}, 32'h1);
      status_clr = 1'b1;
      tick();
      tick();
      check("status_cleared", {31'h0, status}, 32'h0);
      cnt = 6;
      for (int k = 0; k < 300; k++) begin
         cnt = (cnt < 255) ? cnt + 1 : 255;
         issue(8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 8'(cnt));
         tick();
      end
      tick();
      check("count_saturated", {24'h0, hit_count}, 32'd255);

      // 6: async reset between edges discards an in-flight hit
      rd_addr = 2'd0;
      tick();
      in_valid = 1'b1;
      {b, a}   = 8'h00;
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst_rd", rd_data, 32'h0);
      check("async_rst_flags", {29'h0, hit_valid, miss, status}, 32'h0);
      check("async_rst_count", {24'h0, hit_count}, 32'h0);
      tick();
      rstn = 1'b1;
      read_check("post_rst_e0", 2'd0, 32'h0);
      read_check("post_rst_e1", 2'd1, 32'h0);
      read_check("post_rst_e2", 2'd2, 32'h0);
      read_check("post_rst_e3", 2'd3, 32'h0);
      issue(8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'd0);
      tick();
      issue(8'h5A, 1'b0, 2'd0, 1'b1, 1'b0, 8'd0);
      tick();
      tick();
      tick();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
